// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_pkg
//  Description : Shared types and constants for the data cache controller:
//                FSM state encoding, mem_ctrl (funct3) load/store widths and
//                the address-field width helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2
    } state_e;

    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    // Byte offset inside a 32-bit word.
    localparam int OFFSET_W = 2;

    function automatic int word_w(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int index_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_w(input int addr_width, input int lines,
                                 input int words_per_line);
        return addr_width - OFFSET_W - $clog2(words_per_line) - $clog2(lines);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_ctrl_mem_align.sv
`default_nettype none
// ============================================================================
//  Module      : mem_align
//  Description : Combinational load extension and store byte-lane merge for
//                one 32-bit word, using the mem_ctrl (funct3) encoding.
//  Ports       : ctrl        - funct3 width/sign selector
//                addr_lo     - byte offset of the access
//                old_word    - word currently held in the cache
//                wdata       - right-aligned store data
//                merged_word - old_word with the store lanes replaced
//                read_ext    - selected byte/half/word, sign/zero extended
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_align
    import dcache_pkg::*;
(
    input  logic [2:0]  ctrl,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] merged_word,
    output logic [31:0] read_ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = old_word[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? old_word[31:16] : old_word[15:0];

        case (ctrl)
            MEM_B:   read_ext = {{24{byte_sel[7]}}, byte_sel};
            MEM_H:   read_ext = {{16{half_sel[15]}}, half_sel};
            MEM_BU:  read_ext = {24'h0, byte_sel};
            MEM_HU:  read_ext = {16'h0, half_sel};
            default: read_ext = old_word;
        endcase

        // ctrl[1:0] carries the access size for stores (b=00, h=01, w=10).
        merged_word = old_word;
        case (ctrl[1:0])
            2'b00: merged_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            2'b01: begin
                if (addr_lo[1]) merged_word[31:16] = wdata[15:0];
                else            merged_word[15:0]  = wdata[15:0];
            end
            default: merged_word = wdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_ctrl
//  Description : Direct-mapped, write-back, write-allocate data cache for the
//                memory stage. Hits answer combinationally; misses stall the
//                pipeline while a dirty victim is written back and the line is
//                refilled over a word-wide req/ack memory port.
//  Ports       : clk, rst (async, active-high)
//                req_*      - load/store from the memory stage
//                resp_rdata - extended load data, valid when !stall
//                stall      - freeze pipeline (request must be held)
//                mem_*      - one-word beat interface to main memory
//  Revision    : 1.0 - initial release
// ============================================================================
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [2:0]            req_ctrl,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int WORD_W = word_w(WORDS_PER_LINE);
    localparam int IDX_W  = index_w(LINES);
    localparam int TAG_W  = tag_w(ADDR_WIDTH, LINES, WORDS_PER_LINE);
    localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(WORDS_PER_LINE - 1);

    logic [WORD_W-1:0] req_word;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;

    assign req_word = req_addr[OFFSET_W +: WORD_W];
    assign req_idx  = req_addr[OFFSET_W + WORD_W +: IDX_W];
    assign req_tag  = req_addr[ADDR_WIDTH-1 -: TAG_W];

    state_e            state_q, state_d;
    logic [WORD_W-1:0] beat_q, beat_d;
    logic [IDX_W-1:0]  miss_idx_q, miss_idx_d;
    logic [TAG_W-1:0]  miss_tag_q, miss_tag_d;
    logic [LINES-1:0]  valid_q, valid_d;
    logic [LINES-1:0]  dirty_q, dirty_d;

    // Tag and data storage are never cleared; valid_q qualifies them.
    logic [TAG_W-1:0]      tag_q  [LINES];
    logic [DATA_WIDTH-1:0] data_q [LINES][WORDS_PER_LINE];

    logic        active;
    logic        hit;
    logic        beat_done;
    logic        last_beat;
    logic [31:0] store_word;
    logic [31:0] load_word;

    // rst gates the request so stall/resp_rdata drop the moment reset asserts,
    // even with the pipeline still presenting a (frozen) request.
    assign active    = req_valid && !rst && (state_q == IDLE);
    assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign beat_done = mem_ack && (state_q != IDLE);
    assign last_beat = beat_done && (beat_q == LAST_BEAT);

    mem_align u_mem_align (
        .ctrl        (req_ctrl),
        .addr_lo     (req_addr[1:0]),
        .old_word    (data_q[req_idx][req_word]),
        .wdata       (req_wdata),
        .merged_word (store_word),
        .read_ext    (load_word)
    );

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        miss_idx_d = miss_idx_q;
        miss_tag_d = miss_tag_q;
        valid_d    = valid_q;
        dirty_d    = dirty_q;
        case (state_q)
            IDLE: begin
                if (active && !hit) begin
                    // Latch the miss so mem_* depend only on registered state.
                    miss_idx_d = req_idx;
                    miss_tag_d = req_tag;
                    beat_d     = '0;
                    state_d    = (valid_q[req_idx] && dirty_q[req_idx]) ? WRITEBACK : REFILL;
                end else if (active && req_write) begin
                    dirty_d[req_idx] = 1'b1;
                end
            end
            WRITEBACK: begin
                if (beat_done) begin
                    beat_d = beat_q + WORD_W'(1);
                    if (last_beat) begin
                        dirty_d[miss_idx_q] = 1'b0;
                        state_d             = REFILL;
                    end
                end
            end
            REFILL: begin
                if (beat_done) begin
                    beat_d = beat_q + WORD_W'(1);
                    if (last_beat) begin
                        valid_d[miss_idx_q] = 1'b1;
                        dirty_d[miss_idx_q] = 1'b0;
                        state_d             = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            miss_idx_q <= '0;
            miss_tag_q <= '0;
            valid_q    <= '0;
            dirty_q    <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            miss_idx_q <= miss_idx_d;
            miss_tag_q <= miss_tag_d;
            valid_q    <= valid_d;
            dirty_q    <= dirty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == REFILL && beat_done)
            data_q[miss_idx_q][beat_q] <= mem_rdata;
        if (state_q == REFILL && last_beat)
            tag_q[miss_idx_q] <= miss_tag_q;
        if (active && hit && req_write)
            data_q[req_idx][req_word] <= store_word;
    end

    always_comb begin
        stall      = (state_q != IDLE) || (active && !hit);
        resp_rdata = (active && hit) ? load_word : '0;
        mem_req    = (state_q != IDLE);
        mem_we     = (state_q == WRITEBACK);
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state_q)
            WRITEBACK: begin
                mem_addr  = {tag_q[miss_idx_q], miss_idx_q, beat_q, 2'b00};
                mem_wdata = data_q[miss_idx_q][beat_q];
            end
            REFILL:  mem_addr = {miss_tag_q, miss_idx_q, beat_q, 2'b00};
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_dcache_ctrl
//  Description : Self-checking bench for dcache_ctrl. Directed vector table,
//                hand-written wait/reset sequences and random traffic checked
//                against a flat architectural memory plus a tag-state model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [2:0]  req_ctrl  = 3'b000;
    logic [31:0] req_addr  = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [31:0] resp_rdata;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack   = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    dcache_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_ctrl   (req_ctrl),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_rdata (resp_rdata),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    beat_t       log_q[$];
    beat_t       exp_q[$];
    logic [31:0] bmem    [int unsigned];
    logic [31:0] ref_mem [int unsigned];

    int          ack_wait = 0;
    int          wait_cnt = 0;
    int          unstable = 0;
    logic [31:0] hold_addr, hold_wdata;
    logic        hold_we;

    bit          mvalid [16];
    bit          mdirty [16];
    logic [23:0] mtag   [16];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        if (a >= 32'h100 && a < 32'h110) return 32'hA0 + ((a - 32'h100) >> 2);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] bread(input logic [31:0] a);
        return bmem.exists(a) ? bmem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] rread(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] ctrl, input logic [31:0] addr);
        logic [31:0] w, b, h;
        w = rread({addr[31:2], 2'b00});
        b = (w >> (8 * addr[1:0])) & 32'hFF;
        h = (w >> (16 * addr[1])) & 32'hFFFF;
        case (ctrl)
            3'b000:  return b[7]  ? (b | 32'hFFFF_FF00) : b;
            3'b001:  return h[15] ? (h | 32'hFFFF_0000) : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    task automatic ref_store(input logic [2:0] ctrl, input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] a, w, m;
        int          sh;
        a = {addr[31:2], 2'b00};
        w = rread(a);
        if (ctrl[1:0] == 2'b00) begin
            sh = 8 * addr[1:0];
            m  = 32'hFF << sh;
            w  = (w & ~m) | ((wd & 32'hFF) << sh);
        end else if (ctrl[1:0] == 2'b01) begin
            sh = 16 * addr[1];
            m  = 32'hFFFF << sh;
            w  = (w & ~m) | ((wd & 32'hFFFF) << sh);
        end else begin
            w = wd;
        end
        ref_mem[a] = w;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Main-memory responder: ack/rdata driven on the falling edge, beats
    // accepted on the rising edge.
    always @(negedge clk) begin
        mem_ack   = mem_req && (wait_cnt >= ack_wait);
        mem_rdata = (mem_req && !mem_we) ? bread(mem_addr) : 32'h0;
    end

    always @(posedge clk) begin
        if (mem_req) begin
            if (wait_cnt == 0) begin
                hold_addr  = mem_addr;
                hold_we    = mem_we;
                hold_wdata = mem_wdata;
            end else if (mem_addr !== hold_addr || mem_we !== hold_we ||
                         (mem_we && mem_wdata !== hold_wdata)) begin
                unstable++;
            end
            if (mem_ack) begin
                log_q.push_back('{mem_we, mem_addr, mem_wdata});
                if (mem_we) bmem[mem_addr] = mem_wdata;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // One complete access: predicts traffic/stall from the model, runs it,
    // checks stall length, memory beats and load data, then updates the model.
    task automatic do_access(input bit we, input logic [2:0] ctrl, input logic [31:0] addr,
                             input logic [31:0] wdata, input int waits,
                             output logic [31:0] rdata, output int stalls);
        int          idx;
        logic [23:0] tag;
        bit          miss, to, ok;
        int          exp_stalls;
        logic [31:0] exp_rd, a;
        idx  = int'(addr[7:4]);
        tag  = addr[31:8];
        miss = !(mvalid[idx] && mtag[idx] == tag);
        exp_q.delete();
        if (miss) begin
            if (mvalid[idx] && mdirty[idx])
                for (int b = 0; b < 4; b++) begin
                    a = {mtag[idx], addr[7:4], 4'(b << 2)};
                    exp_q.push_back('{1'b1, a, rread(a)});
                end
            for (int b = 0; b < 4; b++)
                exp_q.push_back('{1'b0, {tag, addr[7:4], 4'(b << 2)}, 32'h0});
        end
        exp_stalls = miss ? 1 + exp_q.size() * (waits + 1) : 0;
        exp_rd     = ref_load(ctrl, addr);
        ack_wait   = waits;
        log_q.delete();
        unstable   = 0;

        @(posedge clk); #1;
        req_valid = 1'b1; req_write = we; req_ctrl = ctrl; req_addr = addr; req_wdata = wdata;
        stalls = 0;
        to     = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (!stall) begin
                to = 1'b0;
                break;
            end
            stalls++;
        end
        rdata = resp_rdata;
        @(posedge clk); #1;
        req_valid = 1'b0;

        checks++;
        if (to) begin
            failures++;
            $display("FAIL timeout addr=%h: stall still high after 100 cycles", addr);
        end
        chk($sformatf("stall_len addr=%h", addr), 32'(stalls), 32'(exp_stalls));
        ok = (log_q.size() == exp_q.size());
        if (ok)
            foreach (exp_q[i])
                if (log_q[i].we !== exp_q[i].we || log_q[i].addr !== exp_q[i].addr ||
                    (exp_q[i].we && log_q[i].data !== exp_q[i].data)) ok = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL traffic addr=%h: got %0d beats (first %h/%h) expected %0d beats (first %h/%h)",
                     addr, log_q.size(), log_q.size() ? log_q[0].addr : 32'h0,
                     log_q.size() ? log_q[0].data : 32'h0, exp_q.size(),
                     exp_q.size() ? exp_q[0].addr : 32'h0, exp_q.size() ? exp_q[0].data : 32'h0);
        end
        if (!we) chk($sformatf("load_model addr=%h ctrl=%0d", addr, ctrl), rdata, exp_rd);

        if (miss) begin
            mvalid[idx] = 1'b1;
            mtag[idx]   = tag;
            mdirty[idx] = 1'b0;
        end
        if (we) begin
            mdirty[idx] = 1'b1;
            ref_store(ctrl, addr, wdata);
        end
    endtask

    typedef struct {
        bit          we;
        logic [2:0]  ctrl;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          chk_rd;
        logic [31:0] exp_rd;
        int          exp_stall;
    } vec_t;

    vec_t tbl[14];

    initial begin
        logic [31:0] rd, a;
        int          st, sel, off;
        bit          to, w;
        logic [2:0]  c;
        logic [23:0] rtag;

        tbl[0]  = '{1'b0, 3'b010, 32'h0000_0100, 32'h0,          1'b1, 32'h0000_00A0, 5};
        tbl[1]  = '{1'b1, 3'b000, 32'h0000_0101, 32'h0000_0080,  1'b0, 32'h0,         0};
        tbl[2]  = '{1'b0, 3'b100, 32'h0000_0101, 32'h0,          1'b1, 32'h0000_0080, 0};
        tbl[3]  = '{1'b0, 3'b000, 32'h0000_0101, 32'h0,          1'b1, 32'hFFFF_FF80, 0};
        tbl[4]  = '{1'b0, 3'b101, 32'h0000_0100, 32'h0,          1'b1, 32'h0000_80A0, 0};
        tbl[5]  = '{1'b0, 3'b010, 32'h0000_1100, 32'h0,          1'b1, 32'h5A5A_1100, 9};
        tbl[6]  = '{1'b0, 3'b010, 32'h0000_0100, 32'h0,          1'b1, 32'h0000_80A0, 5};
        tbl[7]  = '{1'b1, 3'b001, 32'h0000_0102, 32'h1234_BEEF,  1'b0, 32'h0,         0};
        tbl[8]  = '{1'b0, 3'b001, 32'h0000_0102, 32'h0,          1'b1, 32'hFFFF_BEEF, 0};
        tbl[9]  = '{1'b0, 3'b010, 32'h0000_0100, 32'h0,          1'b1, 32'hBEEF_80A0, 0};
        tbl[10] = '{1'b0, 3'b000, 32'h0000_0103, 32'h0,          1'b1, 32'hFFFF_FFBE, 0};
        tbl[11] = '{1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF,  1'b0, 32'h0,         0};
        tbl[12] = '{1'b0, 3'b010, 32'h0000_0104, 32'h0,          1'b1, 32'hDEAD_BEEF, 0};
        tbl[13] = '{1'b0, 3'b101, 32'h0000_0106, 32'h0,          1'b1, 32'h0000_DEAD, 0};

        // Reset state, checked while rst is held and after release.
        #12;
        chk("reset_outputs_in_rst", {26'h0, stall, mem_req, mem_we, |mem_addr, |mem_wdata, |resp_rdata}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs_after", {27'h0, stall, mem_req, mem_we, |mem_addr, |mem_wdata}, 32'h0);

        // Directed vectors, zero-wait memory.
        foreach (tbl[i]) begin
            do_access(tbl[i].we, tbl[i].ctrl, tbl[i].addr, tbl[i].wdata, 0, rd, st);
            chk($sformatf("tbl%0d_stall", i), 32'(st), 32'(tbl[i].exp_stall));
            if (tbl[i].chk_rd) chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
        end

        // Clean miss with three wait cycles per beat.
        do_access(1'b0, 3'b010, 32'h0000_2240, 32'h0, 3, rd, st);
        chk("wait3_stall", 32'(st), 32'd17);
        chk("wait3_rdata", rd, 32'h5A5A_2240);
        chk("wait3_stable", 32'(unstable), 32'd0);

        // Reset during the second refill beat.
        ack_wait = 0;
        log_q.delete();
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b0; req_ctrl = 3'b010; req_addr = 32'h0000_0380;
        to = 1'b1;
        for (int c2 = 0; c2 < 50; c2++) begin
            @(negedge clk);
            if (log_q.size() == 1) begin
                to = 1'b0;
                break;
            end
        end
        checks++;
        if (to) begin
            failures++;
            $display("FAIL rst_midburst_setup: first refill beat never acknowledged");
        end
        chk("rst_midburst_req_before", {31'h0, mem_req}, 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("rst_midburst_drop", {30'h0, mem_req, stall}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = 1'b0;
        foreach (mvalid[i]) begin
            mvalid[i] = 1'b0;
            mdirty[i] = 1'b0;
        end
        // Dirty lines are lost by reset: architectural memory is main memory.
        ref_mem.delete();
        foreach (bmem[k]) ref_mem[k] = bmem[k];
        do_access(1'b0, 3'b010, 32'h0000_0380, 32'h0, 0, rd, st);
        chk("rst_reissue_stall", 32'(st), 32'd5);

        // Random traffic over three tags sharing every index.
        for (int n = 0; n < 200; n++) begin
            sel  = $urandom_range(0, 2);
            rtag = (sel == 0) ? 24'h01 : (sel == 1) ? 24'h11 : 24'h22;
            w    = ($urandom_range(0, 9) < 4);
            if (w) begin
                sel = $urandom_range(0, 2);
                c   = (sel == 0) ? 3'b000 : (sel == 1) ? 3'b001 : 3'b010;
            end else begin
                sel = $urandom_range(0, 4);
                c   = (sel == 0) ? 3'b000 : (sel == 1) ? 3'b001 : (sel == 2) ? 3'b010 :
                      (sel == 3) ? 3'b100 : 3'b101;
            end
            off = (c[1:0] == 2'b00) ? $urandom_range(0, 3) :
                  (c[1:0] == 2'b01) ? 2 * $urandom_range(0, 1) : 0;
            a = {rtag, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'(off)};
            do_access(w, c, a, $urandom, $urandom_range(0, 2), rd, st);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
